mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Memory controller between the CPU and a byte-wide synchronous RAM. Serves the
//  MEM stage data port (sized loads/stores, busy/finish handshake) and the IF
//  instruction-fetch port (32-bit fetch). Splits each access into byte beats,
//  little-endian. Arbitrates the two ports: data has priority over fetch.
// PARAMETERS
//  ADDR_W   17   width of mem_a; the low ADDR_W bits of the byte address are driven
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       reset: synchronous, active-high
//  read_i         in   3       load op: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU
//  read_addr_i    in   32      load byte address
//  write_i        in   2       store op: 00 none, 01 SB, 10 SH, 11 SW
//  write_addr_i   in   32      store byte address
//  write_data_i   in   32      store data; low bytes are used
//  read_busy_o    out  1       load in progress
//  write_busy_o   out  1       store in progress
//  read_data_o    out  32      extended load result
//  finish_o       out  1       one-cycle pulse: data access complete
//  if_req_i       in   1       fetch request
//  if_addr_i      in   32      fetch address
//  if_busy_o      out  1       fetch in progress
//  if_data_o      out  32      fetched instruction
//  if_done_o      out  1       one-cycle pulse: if_data_o valid
//  mem_din        in   8       RAM read data; valid one cycle after mem_a is driven
//  mem_dout       out  8       RAM write data
//  mem_a          out  ADDR_W  RAM address
//  mem_wr         out  1       1 = write the RAM at the next edge
// BEHAVIOUR
//  - All outputs are registered. At reset, and whenever no beat is issued:
//    mem_wr=0, mem_a=0, mem_dout=0. Reset also clears busy/finish/done and the
//    data outputs (read_data_o=0, if_data_o=0).
//  - States: IDLE, RD, WR, DONE.
//  - IDLE: a request is accepted at edge E0. Priority: write_i != 0, then
//    read_i != 0, then if_req_i. Byte count N: 1, 2 or 4 (fetch = 4, zero-extended).
//    On acceptance the op, address, data and N are latched, and the beat counter
//    k is set to 0.
//  - RD: at edge E_k (k = 0..N-1), mem_a <= addr + k, with 32-bit wrap. Byte k is
//    captured from mem_din at E_{k+2}. At E_{N+1}, read_data_o/if_data_o is loaded
//    with the assembled value, finish_o/if_done_o <= 1, busy <= 0, next state DONE.
//  - WR: at edge E_k, mem_wr <= 1, mem_a <= addr + k, mem_dout <= byte k of the
//    data. At E_N, mem_wr <= 0, finish_o <= 1, write_busy_o <= 0, next state DONE.
//  - Busy: the selected busy output is high from E0 until the finish edge, and is
//    low in the finish cycle. This lets the MEM stage sample finish && !busy.
//  - DONE: lasts one cycle. Pulses drop at the next edge and the state returns to
//    IDLE. No acceptance in DONE, because the MEM stage drops its request in the
//    finish cycle.
//  - Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
//    Undefined read_i codes (110, 111) are treated as none.
//  - read_data_o and if_data_o hold their value until the next completion on the
//    same port.
//  - Inputs are ignored while the block is busy. A fetch always runs to
//    completion, even if if_req_i drops mid-fetch.
//  - Simultaneous data and fetch requests: data is served first. The fetch is
//    accepted on the IDLE cycle after DONE if if_req_i is still high.
//  - rst during an access: the next edge aborts the access; state <= IDLE,
//    mem_wr <= 0, and no finish/done pulse is produced. A partially written word
//    is left as is in RAM.
// STRUCTURE
//  - Package mem_ctrl_pkg: read/write op encodings, state enum, and a byte-count
//    function (op -> N).
//  - Sub-module load_ext (combinational): takes read op + 32-bit raw bytes and
//    outputs the extended result.
//  - Everything else, including FSM, beat counter and byte assembly, stays in
//    mem_ctrl.
// TESTING
//  - LW 0x100, RAM[0x100..103] = 78 56 34 12 -> mem_a = 100,101,102,103;
//    finish_o at E5; read_data_o = 0x12345678; read_busy_o low in the finish cycle.
//  - LB 0x20 = 0x80 -> 0xFFFFFF80, finish at E2. LBU at the same address ->
//    0x00000080. LH 0x30 = 34 F2 -> 0xFFFFF234.
//  - SW 0x200, data 0xAABBCCDD -> mem_wr high 4 cycles, mem_dout DD,CC,BB,AA;
//    finish at E4; read-back with LW returns 0xAABBCCDD.
//  - SB 0x300, data 0x12345699 -> a single beat writes 0x99; neighbouring bytes
//    are unchanged.
//  - read_i = LW and if_req_i asserted in the same cycle -> load served first.
//    The fetch is accepted after DONE; if_done_o fires with the correct word.
//    finish_o and if_done_o are never high together.
//  - rst asserted mid-SW after 2 beats -> mem_wr = 0 next cycle, no finish_o;
//    only bytes 0..1 are written. A new LW after reset completes normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and helpers for the memory controller.
//   rd_op_e  : load op codes on read_i
//   wr_op_e  : store op codes on write_i
//   state_e  : controller FSM states
//   rd_bytes / wr_bytes : op -> byte beat count
//   rd_valid : true for a defined, non-none load code
package mem_ctrl_pkg;

  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    RD_NONE = 3'b000,
    RD_LB   = 3'b001,
    RD_LH   = 3'b010,
    RD_LW   = 3'b011,
    RD_LBU  = 3'b100,
    RD_LHU  = 3'b101
  } rd_op_e;

  typedef enum logic [1:0] {
    WR_NONE = 2'b00,
    WR_SB   = 2'b01,
    WR_SH   = 2'b10,
    WR_SW   = 2'b11
  } wr_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b01,
    S_WR   = 2'b10,
    S_DONE = 2'b11
  } state_e;

  function automatic logic [CNT_W-1:0] rd_bytes(input rd_op_e op);
    case (op)
      RD_LB, RD_LBU: rd_bytes = CNT_W'(1);
      RD_LH, RD_LHU: rd_bytes = CNT_W'(2);
      default:       rd_bytes = CNT_W'(4);
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] wr_bytes(input wr_op_e op);
    case (op)
      WR_SB:   wr_bytes = CNT_W'(1);
      WR_SH:   wr_bytes = CNT_W'(2);
      default: wr_bytes = CNT_W'(4);
    endcase
  endfunction

  // Codes 110/111 are undefined and behave like "no load".
  function automatic logic rd_valid(input logic [2:0] code);
    rd_valid = (code != 3'b000) && (code <= 3'b101);
  endfunction

endpackage

// File: rtl/mem_ctrl_load_ext.sv
// Combinational load extension.
//   op       : latched load op
//   raw      : assembled little-endian bytes (unused high bytes ignored)
//   result_c : sign/zero-extended load result
module load_ext
  import mem_ctrl_pkg::*;
(
  input  rd_op_e      op,
  input  logic [31:0] raw,
  output logic [31:0] result_c
);

  always_comb begin
    result_c = raw;
    case (op)
      RD_LB:   result_c = {{24{raw[7]}}, raw[7:0]};
      RD_LBU:  result_c = {24'b0, raw[7:0]};
      RD_LH:   result_c = {{16{raw[15]}}, raw[15:0]};
      RD_LHU:  result_c = {16'b0, raw[15:0]};
      default: result_c = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: CPU data port (sized loads/stores) and instruction
// fetch port onto a byte-wide synchronous RAM, one byte beat per cycle,
// little-endian. Data requests win over fetch.
//   clk, rst                 : clock, synchronous active-high reset
//   read_i/read_addr_i       : load op and address
//   write_i/write_addr_i/write_data_i : store op, address, data
//   read_busy_o/write_busy_o : access in progress (low in the finish cycle)
//   read_data_o, finish_o    : load result, data-access completion pulse
//   if_req_i/if_addr_i       : fetch request and address
//   if_busy_o/if_data_o/if_done_o : fetch status, word, completion pulse
//   mem_din/mem_dout/mem_a/mem_wr : RAM interface (read data one cycle late)
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        read_i,
  input  logic [31:0]       read_addr_i,
  input  logic [1:0]        write_i,
  input  logic [31:0]       write_addr_i,
  input  logic [31:0]       write_data_i,
  output logic              read_busy_o,
  output logic              write_busy_o,
  output logic [31:0]       read_data_o,
  output logic              finish_o,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_busy_o,
  output logic [31:0]       if_data_o,
  output logic              if_done_o,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;      // index of the edge being evaluated
  logic [CNT_W-1:0]   nbytes_q, nbytes_d;
  logic               fetch_q, fetch_d;
  rd_op_e             op_q, op_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        raw_q, raw_d;

  logic               read_busy_d, write_busy_d, finish_d;
  logic               if_busy_d, if_done_d;
  logic [31:0]        read_data_d, if_data_d;
  logic [7:0]         mem_dout_d;
  logic [ADDR_W-1:0]  mem_a_d;
  logic               mem_wr_d;

  logic [1:0]         cap_sel;
  logic [31:0]        raw_cap;
  logic [31:0]        ext_c;

  // Byte issued at edge k returns on mem_din in time for edge k+2.
  assign cap_sel = 2'(cnt_q - CNT_W'(2));

  // Raw word including the byte arriving this cycle.
  always_comb begin
    raw_cap = raw_q;
    if (state_q == S_RD && cnt_q >= CNT_W'(2)) begin
      raw_cap[{cap_sel, 3'b000} +: 8] = mem_din;
    end
  end

  load_ext u_load_ext (
    .op       (op_q),
    .raw      (raw_cap),
    .result_c (ext_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    nbytes_d     = nbytes_q;
    fetch_d      = fetch_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    raw_d        = raw_cap;
    read_busy_d  = read_busy_o;
    write_busy_d = write_busy_o;
    read_data_d  = read_data_o;
    if_busy_d    = if_busy_o;
    if_data_d    = if_data_o;
    finish_d     = 1'b0;
    if_done_d    = 1'b0;
    mem_dout_d   = '0;
    mem_a_d      = '0;
    mem_wr_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Acceptance edge doubles as beat 0.
        if (write_i != 2'b00) begin
          state_d      = S_WR;
          nbytes_d     = wr_bytes(wr_op_e'(write_i));
          addr_d       = write_addr_i;
          wdata_d      = write_data_i;
          fetch_d      = 1'b0;
          cnt_d        = CNT_W'(1);
          write_busy_d = 1'b1;
          mem_wr_d     = 1'b1;
          mem_a_d      = ADDR_W'(write_addr_i);
          mem_dout_d   = write_data_i[7:0];
        end else if (rd_valid(read_i)) begin
          state_d      = S_RD;
          op_d         = rd_op_e'(read_i);
          nbytes_d     = rd_bytes(rd_op_e'(read_i));
          addr_d       = read_addr_i;
          fetch_d      = 1'b0;
          cnt_d        = CNT_W'(1);
          raw_d        = '0;
          read_busy_d  = 1'b1;
          mem_a_d      = ADDR_W'(read_addr_i);
        end else if (if_req_i) begin
          state_d      = S_RD;
          op_d         = RD_LW;
          nbytes_d     = CNT_W'(4);
          addr_d       = if_addr_i;
          fetch_d      = 1'b1;
          cnt_d        = CNT_W'(1);
          raw_d        = '0;
          if_busy_d    = 1'b1;
          mem_a_d      = ADDR_W'(if_addr_i);
        end
      end

      S_RD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q < nbytes_q) begin
          mem_a_d = ADDR_W'(addr_q + 32'(cnt_q));
        end
        if (cnt_q == nbytes_q + CNT_W'(1)) begin
          state_d = S_DONE;
          if (fetch_q) begin
            if_data_d = raw_cap;
            if_done_d = 1'b1;
            if_busy_d = 1'b0;
          end else begin
            read_data_d = ext_c;
            finish_d    = 1'b1;
            read_busy_d = 1'b0;
          end
        end
      end

      S_WR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q < nbytes_q) begin
          mem_wr_d   = 1'b1;
          mem_a_d    = ADDR_W'(addr_q + 32'(cnt_q));
          mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        end else begin
          state_d      = S_DONE;
          finish_d     = 1'b1;
          write_busy_d = 1'b0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      nbytes_q     <= '0;
      fetch_q      <= 1'b0;
      op_q         <= RD_NONE;
      addr_q       <= '0;
      wdata_q      <= '0;
      raw_q        <= '0;
      read_busy_o  <= 1'b0;
      write_busy_o <= 1'b0;
      read_data_o  <= '0;
      finish_o     <= 1'b0;
      if_busy_o    <= 1'b0;
      if_data_o    <= '0;
      if_done_o    <= 1'b0;
      mem_dout     <= '0;
      mem_a        <= '0;
      mem_wr       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nbytes_q     <= nbytes_d;
      fetch_q      <= fetch_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      raw_q        <= raw_d;
      read_busy_o  <= read_busy_d;
      write_busy_o <= write_busy_d;
      read_data_o  <= read_data_d;
      finish_o     <= finish_d;
      if_busy_o    <= if_busy_d;
      if_data_o    <= if_data_d;
      if_done_o    <= if_done_d;
      mem_dout     <= mem_dout_d;
      mem_a        <= mem_a_d;
      mem_wr       <= mem_wr_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl with a behavioural byte-wide synchronous RAM.
module tb_mem_ctrl;

  localparam int unsigned AW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    read_i = '0;
  logic [31:0]   read_addr_i = '0;
  logic [1:0]    write_i = '0;
  logic [31:0]   write_addr_i = '0;
  logic [31:0]   write_data_i = '0;
  logic          read_busy_o, write_busy_o, finish_o;
  logic [31:0]   read_data_o;
  logic          if_req_i = 1'b0;
  logic [31:0]   if_addr_i = '0;
  logic          if_busy_o, if_done_o;
  logic [31:0]   if_data_o;
  logic [7:0]    mem_din = '0;
  logic [7:0]    mem_dout;
  logic [AW-1:0] mem_a;
  logic          mem_wr;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .read_i(read_i), .read_addr_i(read_addr_i),
    .write_i(write_i), .write_addr_i(write_addr_i), .write_data_i(write_data_i),
    .read_busy_o(read_busy_o), .write_busy_o(write_busy_o),
    .read_data_o(read_data_o), .finish_o(finish_o),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_busy_o(if_busy_o), .if_data_o(if_data_o), .if_done_o(if_done_o),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a] <= mem_dout;
    mem_din <= ram[mem_a];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;   // 0 load, 1 store, 2 fetch
    logic [31:0] data;
    int          due;
    string       name;
  } exp_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [7:0]    d;
  } beat_t;

  exp_t  dq[$];
  exp_t  fq[$];
  beat_t bq[$];

  int nchk = 0;
  int nerr = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    nchk++;
    nerr++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pops expectations whenever the DUT shows a pulse or a RAM beat.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t  e;
      beat_t b;
      if (finish_o && if_done_o) flag("finish_and_done_overlap");
      if (finish_o) begin
        if (dq.size() == 0) flag("unexpected_finish");
        else begin
          e = dq.pop_front();
          check({e.name, "_finish_cycle"}, 32'(cyc), 32'(e.due));
          check({e.name, "_busy_low"}, {30'b0, read_busy_o, write_busy_o}, 32'b0);
          if (e.kind == 0) check({e.name, "_data"}, read_data_o, e.data);
        end
      end
      if (if_done_o) begin
        if (fq.size() == 0) flag("unexpected_if_done");
        else begin
          e = fq.pop_front();
          check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.due));
          check({e.name, "_if_busy_low"}, {31'b0, if_busy_o}, 32'b0);
          check({e.name, "_if_data"}, if_data_o, e.data);
        end
      end
      if (mem_wr || mem_a != '0) begin
        if (bq.size() == 0) flag("unexpected_beat");
        else begin
          b = bq.pop_front();
          check("beat", {6'b0, mem_wr, mem_a, mem_dout}, {6'b0, b.wr, b.a, b.d});
        end
      end
    end
  end

  task automatic push_beats(input logic wr, input logic [31:0] a, input logic [31:0] wd, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.wr = wr;
      b.a  = AW'(a + 32'(k));
      b.d  = wr ? wd[8*k +: 8] : 8'h00;
      bq.push_back(b);
    end
  endtask

  // Called at a negedge in the IDLE cycle; the next posedge accepts.
  task automatic issue(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp, input string name);
    exp_t e;
    int n;
    case (rd)
      3'd1, 3'd4: n = 1;
      3'd2, 3'd5: n = 2;
      default:    n = 4;
    endcase
    if (wr != 2'd0) n = (wr == 2'd1) ? 1 : (wr == 2'd2) ? 2 : 4;
    e.kind = (wr != 2'd0) ? 1 : 0;
    e.data = exp;
    e.due  = cyc + 1 + ((wr != 2'd0) ? n : n + 1);
    e.name = name;
    dq.push_back(e);
    push_beats(wr != 2'd0, a, wd, n);
    read_i = rd; read_addr_i = a;
    write_i = wr; write_addr_i = a; write_data_i = wd;
    @(negedge clk);
    read_i = '0; write_i = '0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((dq.size() != 0 || fq.size() != 0 || bq.size() != 0) && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    if (dq.size() != 0 || fq.size() != 0 || bq.size() != 0) begin
      flag({name, "_timeout"});
      dq.delete(); fq.delete(); bq.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   c0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'h00;
    {ram[32'h100], ram[32'h101], ram[32'h102], ram[32'h103]} = {8'h78, 8'h56, 8'h34, 8'h12};
    ram[32'h20] = 8'h80;
    {ram[32'h30], ram[32'h31]} = {8'h34, 8'hF2};
    {ram[32'h300], ram[32'h301], ram[32'h302], ram[32'h303]} = {8'h01, 8'h02, 8'h03, 8'h04};
    {ram[32'h400], ram[32'h401], ram[32'h402], ram[32'h403]} = {8'h93, 8'h00, 8'hA0, 8'h00};
    for (int i = 0; i < 4; i++) ram[32'h500 + i] = 8'hEE;

    repeat (3) @(negedge clk);
    check("rst_busy", {29'b0, read_busy_o, write_busy_o, if_busy_o}, 32'b0);
    check("rst_pulses", {30'b0, finish_o, if_done_o}, 32'b0);
    check("rst_read_data", read_data_o, 32'b0);
    check("rst_if_data", if_data_o, 32'b0);
    check("rst_mem", {6'b0, mem_wr, mem_a, mem_dout}, 32'b0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    issue(3'd3, 2'd0, 32'h100, 32'h0, 32'h12345678, "lw_100");
    check("lw_busy_mid", {31'b0, read_busy_o}, 32'd1);
    drain("lw_100");
    issue(3'd1, 2'd0, 32'h20, 32'h0, 32'hFFFFFF80, "lb_20");   drain("lb_20");
    issue(3'd4, 2'd0, 32'h20, 32'h0, 32'h00000080, "lbu_20");  drain("lbu_20");
    issue(3'd2, 2'd0, 32'h30, 32'h0, 32'hFFFFF234, "lh_30");   drain("lh_30");
    issue(3'd5, 2'd0, 32'h30, 32'h0, 32'h0000F234, "lhu_30");  drain("lhu_30");
    issue(3'd0, 2'd3, 32'h200, 32'hAABBCCDD, 32'h0, "sw_200"); drain("sw_200");
    issue(3'd3, 2'd0, 32'h200, 32'h0, 32'hAABBCCDD, "lw_200"); drain("lw_200");
    issue(3'd0, 2'd1, 32'h300, 32'h12345699, 32'h0, "sb_300"); drain("sb_300");
    issue(3'd3, 2'd0, 32'h300, 32'h0, 32'h04030299, "lw_300"); drain("lw_300");

    // Load and fetch in the same cycle: load first, fetch after DONE.
    c0 = cyc;
    e.kind = 2; e.data = 32'h00A00093; e.due = c0 + 1 + 12; e.name = "fetch_400";
    fq.push_back(e);
    if_req_i = 1'b1; if_addr_i = 32'h400;
    issue(3'd3, 2'd0, 32'h100, 32'h0, 32'h12345678, "lw_arb");
    push_beats(1'b0, 32'h400, 32'h0, 4);
    repeat (7) @(negedge clk);
    check("fetch_busy_after_accept", {31'b0, if_busy_o}, 32'd1);
    if_req_i = 1'b0;
    drain("arb");
    check("read_data_held", read_data_o, 32'h12345678);

    // Reset in the middle of a store after two beats.
    push_beats(1'b1, 32'h500, 32'h11223344, 2);
    write_i = 2'd3; write_addr_i = 32'h500; write_data_i = 32'h11223344;
    @(negedge clk);
    write_i = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    check("abort_mem_wr", {31'b0, mem_wr}, 32'b0);
    check("abort_busy", {30'b0, write_busy_o, finish_o}, 32'b0);
    check("abort_beats_done", 32'(bq.size()), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_ram", {ram[32'h503], ram[32'h502], ram[32'h501], ram[32'h500]}, 32'hEEEE3344);
    issue(3'd3, 2'd0, 32'h500, 32'h0, 32'hEEEE3344, "lw_500"); drain("lw_500");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
